// File: rtl/div_iter_pkg.sv
// Shared pipeline definitions used by the iterative divider:
// FSM state encoding, iteration count, divide-by-zero quotient and
// small two's-complement helpers.
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // One restoring step per quotient bit.
  localparam int DIV_STEPS = 32;

  // Width of the step counter; it must be able to hold DIV_STEPS-1.
  localparam int DIV_CNT_W = 5;

  // Quotient reported for a zero divisor; the remainder reports the dividend.
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

  // Magnitude of a signed operand. Unsigned operands pass through untouched.
  // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation for the final sign fix.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step, purely combinational.
// {rem, quo} is shifted left by one, the divisor is trial-subtracted
// from the widened remainder, and the difference is kept only when no
// borrow occurs; the new quotient bit is the inverted borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // Shifted remainder needs one extra bit: with a divisor above 2^(WIDTH-1)
  // the partial remainder can reach bit WIDTH after the shift.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};

  // Trial subtraction; the extra top bit of the result is the borrow-out.
  assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, i_div};

  // Restore on borrow, otherwise commit the difference. Since the partial
  // remainder is always below the divisor, the committed value fits WIDTH bits.
  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for the EX stage (DIV/DIVU).
// IDLE accepts a request, BUSY runs 32 single-bit steps, DONE presents
// the sign-corrected quotient (lo_o) and remainder (hi_o) until the
// pipeline is free to move on. annul aborts, hold parks the result.
module div_iter
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  input  logic             annul,
  input  logic             hold,
  output logic             stall_divE,
  output logic             ready,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  div_state_t           r_state;
  div_state_t           w_state_next;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_div;
  logic                 r_qneg;
  logic                 r_rneg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH-1:0]     w_step_rem;
  logic [WIDTH-1:0]     w_step_quo;
  logic                 w_b_zero;
  logic                 w_last;
  logic                 w_stall;

  assign w_b_zero = (bE == '0);
  assign w_last   = (r_state == BUSY) && (r_cnt == DIV_CNT_W'(DIV_STEPS - 1));

  // The restoring step works on magnitudes; signs are applied only at the end.
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stall decode. annul beats hold and startE in every state.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (startE && !annul) begin
          w_stall      = 1'b1;
          w_state_next = w_b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_stall = !annul;
        if (annul) begin
          w_state_next = IDLE;
        end else if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (annul || !hold) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-cycle step, and result registration.
  // An annulled cycle leaves every datapath register, including hi/lo, alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (!annul) begin
      case (r_state)
        IDLE: begin
          if (startE) begin
            if (w_b_zero) begin
              // Zero divisor: no iteration, fixed quotient, dividend as remainder.
              r_lo <= DIV0_QUO;
              r_hi <= aE;
            end else begin
              // Dividend magnitude enters the low half of {rem, quo}.
              r_quo  <= abs_if(aE, signedE);
              r_div  <= abs_if(bE, signedE);
              r_rem  <= '0;
              r_cnt  <= '0;
              r_qneg <= signedE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
              r_rneg <= signedE & aE[WIDTH-1];
            end
          end
        end
        BUSY: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + DIV_CNT_W'(1);
          if (w_last) begin
            // Final step and sign fix land in the same edge as entry to DONE.
            // 0x80000000 / -1 wraps back to 0x80000000 with no trap.
            r_lo <= neg_if(w_step_quo, r_qneg);
            r_hi <= neg_if(w_step_rem, r_rneg);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stall_divE = w_stall;
  assign ready      = (r_state == DONE);
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider for the EX stage of the five-stage MIPS pipeline. It executes DIV/DIVU and writes quotient/remainder for HI/LO. It drives the `stall_divE` input of the hazard unit, which freezes F/D/E and bubbles M while a division is in flight. It accepts annul (exception flush) and global-hold (cache stall) controls from the same hazard logic.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `startE`  in  1  EX holds a DIV/DIVU; sampled only in IDLE.
- `signedE`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `aE`  in  32  dividend (forwarded rs value).
- `bE`  in  32  divisor (forwarded rt value).
- `annul`  in  1  exception flush (`flush_except`); aborts any operation.
- `hold`  in  1  global memory stall (`i_stall | d_stall`); freezes the DONE state.
- `stall_divE`  out  1  combinational; high while the EX instruction must wait.
- `ready`  out  1  registered result valid (DONE state).
- `hi_o`  out  32  remainder.
- `lo_o`  out  32  quotient.

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with counter = 0, `ready` = 0, `hi_o` = 0 and `lo_o` = 0.
- IDLE -> BUSY: `startE & ~annul & (bE != 0)`.
  - Latch |a| and |b|. The absolute value applies only when `signedE` = 1.
  - Latch the quotient-sign flag: sign(a) XOR sign(b).
  - Latch the remainder-sign flag: sign(a).
  - Clear the 64-bit partial remainder and the counter.
- IDLE -> DONE (divide by zero): `startE & ~annul & (bE == 0)`. Set `lo_o` = 32'hFFFFFFFF and `hi_o` = `aE`, in both modes.
- BUSY: each cycle performs one restoring step.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor using a 33-bit subtraction.
  - If the borrow is 0, commit the difference and set quo[0] = 1.
  - Increment the counter. At counter = 31 the step completes and the state goes to DONE.
- On entry to DONE, apply the sign fix:
  - Negate the quotient if the quotient-sign flag is set.
  - Negate the remainder if the remainder-sign flag is set.
  - Register the results into `hi_o`/`lo_o` in the same edge.
- Signed 0x80000000 / 0xFFFFFFFF gives `lo_o` = 0x80000000 and `hi_o` = 0 (wraps; no trap).
- DONE: `ready` = 1 and `stall_divE` = 0.
  - Stay in DONE while `hold` = 1; `hi_o`/`lo_o` stay stable.
  - Go to IDLE when `hold` = 0.
- `stall_divE` = `(IDLE & startE & ~annul) | (BUSY & ~annul)`.
- `annul` = 1 in any state forces IDLE at the next edge and clears `ready`. `hi_o`/`lo_o` are unchanged.
- `annul` has priority over `hold` and `startE`.
- A `startE` that is still high on the IDLE cycle after DONE starts a new division. The hazard unit guarantees EX advances on the first cycle in DONE with `hold` = 0.

## Timing
- Accept cycle T: `stall_divE` = 1 combinationally in cycle T.
- BUSY occupies cycles T+1 .. T+32; `stall_divE` = 1 throughout.
- DONE at T+33: `ready` = 1, results valid, `stall_divE` = 0. EX advances at the end of T+33.
- Total division latency is 33 cycles. EX sees 33 stalled cycles, including T.
- Divide by zero: DONE at T+1; `stall_divE` = 1 only in T.
- `hold` high during BUSY does not pause iteration. The result waits in DONE.
- `rst` dominates everything, including `annul`.

## Structure
- The shared `cpu_defs` package holds:
  - the `div_state_t` enum {IDLE, BUSY, DONE};
  - `DIV_STEPS` = 32;
  - `DIV0_QUO` = 32'hFFFFFFFF.
- Sub-module `div_step`: a combinational single restoring step taking {rem, quo, divisor} to {rem', quo'}. This keeps the FSM file small and lets the step be unit-tested alone.
- Counter width is 5 bits.

## Test plan
- DIVU 100 / 7: `stall_divE` high for exactly 33 cycles, then `ready` = 1 with `lo_o` = 14 and `hi_o` = 2.
- DIV -7 / 2 (0xFFFFFFF9, 2): `lo_o` = 0xFFFFFFFD (-3), `hi_o` = 0xFFFFFFFF (-1). Also DIV 7 / -2: `lo_o` = -3, `hi_o` = 1.
- DIV 0x80000000 / 0xFFFFFFFF: `lo_o` = 0x80000000, `hi_o` = 0, no trap. DIVU 5 / 0: DONE at T+1 with `lo_o` = 0xFFFFFFFF and `hi_o` = 5.
- Assert `annul` at BUSY cycle 10: next cycle IDLE, `stall_divE` = 0 in the annul cycle, `ready` never rises. A following DIVU 9 / 3 gives 3 r 0.
- Hold `hold` = 1 for 5 cycles starting at the DONE cycle: `ready` stays 1 and the outputs stay stable. IDLE follows the first cycle with `hold` = 0.
- Pulse `rst` in BUSY at cycle 20: next cycle IDLE with `ready` = 0, `hi_o` = 0, `lo_o` = 0, `stall_divE` = 0 (with `startE` low).
